// File: rtl/mem_access_stage.sv
// MEM-stage controller: runs the load/store handshake with a variable-latency
// data memory, stalls upstream while an access is outstanding and feeds MEM/WB.
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [4:0]        WriteBackPath_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] mux0_o,
    output logic [DATA_W-1:0] mux1_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [4:0]        WriteBackPath_o,
    output logic              stall_o,
    output logic              err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam bit               TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              req_int;
    logic              mem_op;

    assign mem_op = MemRead_i | MemWrite_i;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        req_int = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    req_int = 1'b1;
                    cnt_d   = '0;
                    if (mem_ack_i) begin
                        if (!MemWrite_i) rdata_d = mem_rdata_i;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                req_int = 1'b1;
                cnt_d   = cnt_q + CNT_ONE;
                if (mem_ack_i) begin
                    if (!MemWrite_i) rdata_d = mem_rdata_i;
                    state_d = ST_DONE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    // Forced completion: hand WB a zero and flag the hang.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Gating with rst_i drops the request in the same instant reset asserts.
    assign mem_req_o       = req_int & rst_i;
    assign stall_o         = req_int & rst_i;
    assign RegWrite_o      = RegWrite_i & rst_i & ~req_int;
    assign mem_we_o        = MemWrite_i;
    assign mem_addr_o      = alu_result_i;
    assign mem_wdata_o     = store_data_i;
    assign mux0_o          = rdata_q;
    assign mux1_o          = alu_result_i;
    assign MemtoReg_o      = MemtoReg_i;
    assign WriteBackPath_o = WriteBackPath_i;
    assign err_o           = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores,
// back-to-back ops, timeout and asynchronous reset during an access.
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] alu_result_i, store_data_i, mem_rdata_i;
    logic        MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i, mem_ack_i;
    logic [4:0]  WriteBackPath_i;
    logic        mem_req_o, mem_we_o, RegWrite_o, MemtoReg_o, stall_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mux0_o, mux1_o;
    logic [4:0]  WriteBackPath_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    mem_access_stage #(.DATA_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .WriteBackPath_i(WriteBackPath_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .mux0_o(mux0_o), .mux1_o(mux1_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .WriteBackPath_o(WriteBackPath_o),
        .stall_o(stall_o), .err_o(err_o)
    );

    task automatic drive(input logic [31:0] alu, input logic [31:0] sd,
                         input logic mr, input logic mw, input logic rw,
                         input logic m2r, input logic [4:0] wb);
        alu_result_i = alu; store_data_i = sd; MemRead_i = mr; MemWrite_i = mw;
        RegWrite_i = rw; MemtoReg_i = m2r; WriteBackPath_i = wb;
    endtask

    task automatic set_mem(input logic ack, input logic [31:0] rd);
        mem_ack_i = ack; mem_rdata_i = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        drive(32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        set_mem(1'b1, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL reset_req got=%b exp=0", mem_req_o); else n_pass++;
        n_chk++; if (stall_o !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_o); else n_pass++;
        n_chk++; if (RegWrite_o !== 1'b0) $display("FAIL reset_regwrite got=%b exp=0", RegWrite_o); else n_pass++;
        n_chk++; if (err_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_o); else n_pass++;
        n_chk++; if (mux0_o !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", mux0_o); else n_pass++;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        set_mem(1'b0, 32'h0);
        #1 rst_i = 1'b1;
        next_cycle();
        $display("reset: done");
    endtask

    task automatic test_alu_pass();
        drive(32'h2A, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
        set_mem(1'b1, 32'hBAD0_BAD0);  // stray ack with no request
        @(negedge clk_i);
        n_chk++; if (stall_o !== 1'b0) $display("FAIL alu_stall got=%b exp=0", stall_o); else n_pass++;
        n_chk++; if (mux1_o !== 32'h2A) $display("FAIL alu_mux1 got=%h exp=0000002a", mux1_o); else n_pass++;
        n_chk++; if (RegWrite_o !== 1'b1) $display("FAIL alu_regwrite got=%b exp=1", RegWrite_o); else n_pass++;
        n_chk++; if (WriteBackPath_o !== 5'd5) $display("FAIL alu_wbpath got=%0d exp=5", WriteBackPath_o); else n_pass++;
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL alu_req got=%b exp=0", mem_req_o); else n_pass++;
        next_cycle();
        set_mem(1'b0, 32'h0);
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk_i);
        n_chk++; if (mux0_o !== 32'h0) $display("FAIL alu_ack_ignored got=%h exp=0", mux0_o); else n_pass++;
        next_cycle();
        $display("alu: ADD r5=0x2a");
    endtask

    task automatic test_load();
        drive(32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
        for (int c = 0; c < 3; c++) begin
            set_mem(c == 2, (c == 2) ? 32'hDEAD_BEEF : 32'h0);
            @(negedge clk_i);
            n_chk++; if (stall_o !== 1'b1) $display("FAIL load_stall_c%0d got=%b exp=1", c, stall_o); else n_pass++;
            n_chk++; if (RegWrite_o !== 1'b0) $display("FAIL load_regwrite_c%0d got=%b exp=0", c, RegWrite_o); else n_pass++;
            n_chk++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h100)
                $display("FAIL load_req_c%0d got=%b/%b/%h exp=1/0/00000100", c, mem_req_o, mem_we_o, mem_addr_o);
            else n_pass++;
            next_cycle();
        end
        set_mem(1'b0, 32'h0);
        @(negedge clk_i);
        n_chk++; if (mux0_o !== 32'hDEAD_BEEF) $display("FAIL load_rdata got=%h exp=deadbeef", mux0_o); else n_pass++;
        n_chk++; if (RegWrite_o !== 1'b1 || MemtoReg_o !== 1'b1) $display("FAIL load_done_ctrl got=%b/%b exp=1/1", RegWrite_o, MemtoReg_o); else n_pass++;
        n_chk++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) $display("FAIL load_done_stall got=%b/%b exp=0/0", stall_o, mem_req_o); else n_pass++;
        next_cycle();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        $display("load: [0x100] -> 0x%h", mux0_o);
    endtask

    task automatic test_store();
        drive(32'h40, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 32'hCAFE_F00D);
        @(negedge clk_i);
        n_chk++; if (mem_we_o !== 1'b1 || stall_o !== 1'b1) $display("FAIL store_c0 got we=%b stall=%b exp=1/1", mem_we_o, stall_o); else n_pass++;
        n_chk++; if (mem_wdata_o !== 32'h1234_5678 || mem_addr_o !== 32'h40)
            $display("FAIL store_bus got=%h@%h exp=12345678@00000040", mem_wdata_o, mem_addr_o);
        else n_pass++;
        next_cycle();
        set_mem(1'b0, 32'h0);
        @(negedge clk_i);
        n_chk++; if (stall_o !== 1'b0 || RegWrite_o !== 1'b0) $display("FAIL store_done got stall=%b rw=%b exp=0/0", stall_o, RegWrite_o); else n_pass++;
        n_chk++; if (mux0_o !== 32'hDEAD_BEEF) $display("FAIL store_keeps_rdata got=%h exp=deadbeef", mux0_o); else n_pass++;
        next_cycle();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        $display("store: 0x12345678 -> [0x40]");
    endtask

    task automatic test_back_to_back();
        logic [4:0]  stall_exp;
        logic [4:0]  ack_pat;
        logic [31:0] rd;
        stall_exp = 5'b01011;  // cycle c at bit c: 1,1,0,1,0
        ack_pat   = 5'b01010;
        for (int c = 0; c < 5; c++) begin
            if (c < 2) drive(32'h200, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
            else       drive(32'h204, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
            rd = (c < 2) ? 32'h1111_1111 : 32'h2222_2222;
            set_mem(ack_pat[c], rd);
            @(negedge clk_i);
            n_chk++; if (stall_o !== stall_exp[c]) $display("FAIL b2b_stall_c%0d got=%b exp=%b", c, stall_o, stall_exp[c]); else n_pass++;
            if (c == 2) begin
                n_chk++; if (mux0_o !== 32'h1111_1111) $display("FAIL b2b_rdata0 got=%h exp=11111111", mux0_o); else n_pass++;
            end
            if (c == 4) begin
                n_chk++; if (mux0_o !== 32'h2222_2222) $display("FAIL b2b_rdata1 got=%h exp=22222222", mux0_o); else n_pass++;
            end
            next_cycle();
        end
        drive(32'h300, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 32'h3333_3333);
        @(negedge clk_i);
        n_chk++; if (mem_we_o !== 1'b1) $display("FAIL both_we got=%b exp=1", mem_we_o); else n_pass++;
        next_cycle();
        set_mem(1'b0, 32'h0);
        @(negedge clk_i);
        n_chk++; if (mux0_o !== 32'h2222_2222) $display("FAIL both_no_capture got=%h exp=22222222", mux0_o); else n_pass++;
        next_cycle();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        $display("back_to_back: loads 0x11111111, 0x22222222, read+write as store");
    endtask

    task automatic test_timeout();
        drive(32'h500, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
        set_mem(1'b0, 32'h7777_7777);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            n_chk++; if (stall_o !== 1'b1 || err_o !== 1'b0) $display("FAIL to_wait_c%0d got stall=%b err=%b exp=1/0", c, stall_o, err_o); else n_pass++;
            next_cycle();
        end
        @(negedge clk_i);
        n_chk++; if (stall_o !== 1'b0 || mux0_o !== 32'h0) $display("FAIL to_done got stall=%b rdata=%h exp=0/0", stall_o, mux0_o); else n_pass++;
        n_chk++; if (err_o !== 1'b1) $display("FAIL to_err got=%b exp=1", err_o); else n_pass++;
        next_cycle();
        drive(32'h44, 32'h9, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 32'h0);
        next_cycle();
        set_mem(1'b0, 32'h0);
        @(negedge clk_i);
        n_chk++; if (err_o !== 1'b1) $display("FAIL to_err_sticky got=%b exp=1", err_o); else n_pass++;
        next_cycle();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        $display("timeout: load [0x500] forced, err=%b", err_o);
    endtask

    task automatic test_reset_mid_busy();
        drive(32'h600, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
        set_mem(1'b0, 32'h0);
        next_cycle();
        @(negedge clk_i);
        n_chk++; if (stall_o !== 1'b1) $display("FAIL rstb_busy got=%b exp=1", stall_o); else n_pass++;
        #1 rst_i = 1'b0;
        #1;
        n_chk++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) $display("FAIL rstb_drop got req=%b stall=%b exp=0/0", mem_req_o, stall_o); else n_pass++;
        n_chk++; if (err_o !== 1'b0) $display("FAIL rstb_err got=%b exp=0", err_o); else n_pass++;
        next_cycle();
        rst_i = 1'b1;
        drive(32'h604, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
        set_mem(1'b1, 32'h0BAD_CAFE);
        @(negedge clk_i);
        n_chk++; if (stall_o !== 1'b1 || mem_req_o !== 1'b1) $display("FAIL rstb_new_req got=%b/%b exp=1/1", stall_o, mem_req_o); else n_pass++;
        next_cycle();
        set_mem(1'b0, 32'h0);
        @(negedge clk_i);
        n_chk++; if (mux0_o !== 32'h0BAD_CAFE || RegWrite_o !== 1'b1 || stall_o !== 1'b0)
            $display("FAIL rstb_new_done got=%h rw=%b stall=%b exp=0badcafe/1/0", mux0_o, RegWrite_o, stall_o);
        else n_pass++;
        next_cycle();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        $display("reset_mid_busy: recovered, load -> 0x%h", mux0_o);
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load();
        test_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
